// File: rtl/bpf_pipeline_sequencer_if.sv
// Handshake bundle between the BPF pipeline sequencer and the stage0/stage1 datapath.
// The master side is the fetch/decode datapath; the slave side is the sequencer.
interface bpf_pipeline_sequencer_if;
  logic start;
  logic stage1_stalled;
  logic A_en_decoded;
  logic X_en_decoded;
  logic PC_en_decoded;
  logic ret_decoded;
  logic branch_taken;
  logic fetch_en;
  logic pc_rst;
  logic stage1_valid;
  logic stage2_valid;
  logic stage3_valid;
  logic stage2_A_en;
  logic stage2_X_en;
  logic stage3_A_en;
  logic stage3_X_en;
  logic done;
  logic timeout;

  modport master (
    output start, stage1_stalled, A_en_decoded, X_en_decoded, PC_en_decoded,
           ret_decoded, branch_taken,
    input  fetch_en, pc_rst, stage1_valid, stage2_valid, stage3_valid,
           stage2_A_en, stage2_X_en, stage3_A_en, stage3_X_en, done, timeout
  );

  modport slave (
    input  start, stage1_stalled, A_en_decoded, X_en_decoded, PC_en_decoded,
           ret_decoded, branch_taken,
    output fetch_en, pc_rst, stage1_valid, stage2_valid, stage3_valid,
           stage2_A_en, stage2_X_en, stage3_A_en, stage3_X_en, done, timeout
  );
endinterface

// File: rtl/bpf_pipeline_sequencer.sv
// Run-state FSM and per-stage valid/enable bookkeeping for the four-stage BPF pipeline:
// start, fetch gating, stall bubbles, jump squash, RET drain and cycle-limit abort.
module bpf_pipeline_sequencer #(
  parameter int CYCLE_LIMIT = 1024,
  parameter int CNT_W       = 11
) (
  input logic                    clk,
  input logic                    rst,
  bpf_pipeline_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic a_en;
    logic x_en;
    logic pc_en;
    logic ret;
  } s2_fields_t;

  typedef struct packed {
    logic a_en;
    logic x_en;
    logic ret;
  } s3_fields_t;

  state_t           state;
  logic [3:1]       vld_pipe;
  s2_fields_t       s2;
  s3_fields_t       s3;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             timeout_q;

  logic active, accept, hold, squash, ret_accept, limit_hit, fetch, s3_ret;

  assign active     = (state == RUN) || (state == DRAIN);
  assign accept     = vld_pipe[1] && !bus.stage1_stalled;
  assign hold       = vld_pipe[1] &&  bus.stage1_stalled;
  assign squash     = vld_pipe[2] && s2.pc_en && bus.branch_taken;
  assign ret_accept = accept && bus.ret_decoded;
  assign limit_hit  = active && (cnt == CNT_W'(CYCLE_LIMIT - 1));
  assign fetch      = (state == RUN) && !hold && !ret_accept;
  assign s3_ret     = vld_pipe[3] && s3.ret;

  // Valid bits and captured enables; timeout beats squash beats hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s2       <= '0;
      s3       <= '0;
    end else begin
      if (limit_hit || squash) vld_pipe[1] <= 1'b0;
      else if (!hold)          vld_pipe[1] <= fetch;
      vld_pipe[2] <= accept && !squash && !limit_hit;
      vld_pipe[3] <= vld_pipe[2] && !limit_hit;
      if (accept && !squash && !limit_hit)
        s2 <= '{a_en: bus.A_en_decoded, x_en: bus.X_en_decoded,
                pc_en: bus.PC_en_decoded, ret: bus.ret_decoded};
      s3 <= '{a_en: s2.a_en, x_en: s2.x_en, ret: s2.ret};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (active) cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: if (bus.start) begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN, DRAIN: begin
          if (limit_hit) begin
            state     <= DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (s3_ret) begin
            state  <= DONE;
            done_q <= 1'b1;
          // A squashed RET never reaches stage2, so it must not start the drain.
          end else if (state == RUN && ret_accept && !squash) begin
            state <= DRAIN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fetch_en     = fetch;
  assign bus.pc_rst       = (state == IDLE) && bus.start && !rst;
  assign bus.stage1_valid = vld_pipe[1];
  assign bus.stage2_valid = vld_pipe[2];
  assign bus.stage3_valid = vld_pipe[3];
  assign bus.stage2_A_en  = vld_pipe[2] && s2.a_en;
  assign bus.stage2_X_en  = vld_pipe[2] && s2.x_en;
  assign bus.stage3_A_en  = vld_pipe[3] && s3.a_en;
  assign bus.stage3_X_en  = vld_pipe[3] && s3.x_en;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_bpf_pipeline_sequencer.sv
// Bench for bpf_pipeline_sequencer: a small fetch/decode environment runs tiny programs,
// a scoreboard checks the stage3 instruction stream, and per-cycle traces check timing.
module tb_bpf_pipeline_sequencer;
  localparam int LIMIT = 16;

  typedef struct packed {
    logic       a;
    logic       x;
    logic       jmp;
    logic       ret;
    logic       rd;
    logic [3:0] tgt;
  } instr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpf_pipeline_sequencer_if bus();
  bpf_pipeline_sequencer #(.CYCLE_LIMIT(LIMIT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  wire [10:0] outs = {bus.fetch_en, bus.pc_rst, bus.stage1_valid, bus.stage2_valid,
                      bus.stage3_valid, bus.stage2_A_en, bus.stage2_X_en,
                      bus.stage3_A_en, bus.stage3_X_en, bus.done, bus.timeout};

  int n_chk = 0;
  int n_fail = 0;

  instr_t prog [16];
  instr_t sb [$];
  logic   sb_on;
  int     pc, s1_idx, s2_idx, cyc_n, start_at, done_at;
  logic   tmo_seen;
  logic   fe_tr [64];
  logic   pr_tr [64];
  logic   s1v_tr [64];
  logic   s2v_tr [64];
  logic   s3v_tr [64];
  logic   s2a_tr [64];
  logic   s3a_tr [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic instr_t mk(input logic a, input logic x, input logic j,
                                input logic r, input logic rd, input logic [3:0] t);
    instr_t i;
    i.a = a; i.x = x; i.jmp = j; i.ret = r; i.rd = rd; i.tgt = t;
    return i;
  endfunction

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = '0;
    sb.delete();
    sb_on = 1'b1;
  endtask

  // Stage1 decoder model: stalls a reader of A while an older A write is in flight.
  task automatic drive();
    instr_t in;
    in = prog[s1_idx % 16];
    bus.A_en_decoded   = in.a;
    bus.X_en_decoded   = in.x;
    bus.PC_en_decoded  = in.jmp;
    bus.ret_decoded    = in.ret;
    bus.stage1_stalled = in.rd && (bus.stage2_A_en || bus.stage3_A_en);
    bus.branch_taken   = prog[s2_idx % 16].jmp;
  endtask

  task automatic cyc();
    logic fe, pr, acc, tk;
    int   s2o;
    instr_t e;
    fe  = bus.fetch_en;
    pr  = bus.pc_rst;
    acc = bus.stage1_valid && !bus.stage1_stalled;
    tk  = bus.branch_taken && bus.stage2_valid;
    s2o = s2_idx;
    @(posedge clk); #1;
    if (acc) s2_idx = s1_idx;
    if (fe)  s1_idx = pc;
    if (pr)      pc = 0;
    else if (tk) pc = int'(prog[s2o % 16].tgt);
    else if (fe) pc = pc + 1;
    cyc_n++;
    bus.start = (cyc_n == start_at);
    drive();
    #1;
    if (cyc_n < 64) begin
      fe_tr[cyc_n]  = bus.fetch_en;
      pr_tr[cyc_n]  = bus.pc_rst;
      s1v_tr[cyc_n] = bus.stage1_valid;
      s2v_tr[cyc_n] = bus.stage2_valid;
      s3v_tr[cyc_n] = bus.stage3_valid;
      s2a_tr[cyc_n] = bus.stage2_A_en;
      s3a_tr[cyc_n] = bus.stage3_A_en;
    end
    if (sb_on && bus.stage3_valid) begin
      if (sb.size() == 0) chk("sb_extra", bus.stage3_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk("s3_A_en", bus.stage3_A_en, e.a);
        chk("s3_X_en", bus.stage3_X_en, e.x);
      end
    end
  endtask

  task automatic run(input int budget, input int rst_at);
    pc = 0; s1_idx = 0; s2_idx = 0; cyc_n = 0; done_at = 0; tmo_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      fe_tr[i] = 0; pr_tr[i] = 0; s1v_tr[i] = 0; s2v_tr[i] = 0;
      s3v_tr[i] = 0; s2a_tr[i] = 0; s3a_tr[i] = 0;
    end
    bus.start = 1'b1;
    drive();
    #1;
    chk("pc_rst_on_start", bus.pc_rst, 1'b1);
    chk("fetch_in_idle", bus.fetch_en, 1'b0);
    do cyc(); while (!bus.done && cyc_n < budget && cyc_n != rst_at);
    if (cyc_n == rst_at) return;
    chk("done_in_budget", bus.done, 1'b1);
    if (bus.done) begin
      done_at  = cyc_n;
      tmo_seen = bus.timeout;
      cyc();
      chk("done_one_cycle", bus.done, 1'b0);
      chk("timeout_clear", bus.timeout, 1'b0);
      chk("sb_drained", sb.size(), 0);
    end
  endtask

  // n independent instructions then RET; stage3 must see them all, in order.
  task automatic load_line(input int n);
    clr_prog();
    for (int i = 0; i < n; i++) prog[i] = mk(i[0], i[1], 1'b0, 1'b0, 1'b0, 4'd0);
    prog[n] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i <= n; i++) sb.push_back(prog[i]);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; start_at = -1; cyc_n = 0;
    pc = 0; s1_idx = 0; s2_idx = 0;
    clr_prog();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs, 11'd0);
    rst = 1'b0;
    #1;

    // Straight line: 5 instructions + RET.
    load_line(5);
    run(40, -1);
    chk("sl_done_at", done_at, 10);
    chk("sl_timeout", tmo_seen, 1'b0);
    chk("sl_s1v_r1", s1v_tr[1], 1'b0);
    chk("sl_s1v_r2", s1v_tr[2], 1'b1);
    chk("sl_s3v_r3", s3v_tr[3], 1'b0);
    for (int i = 4; i <= 9; i++) chk("sl_s3v_cont", s3v_tr[i], 1'b1);
    chk("sl_fe_ret_accept", fe_tr[7], 1'b0);
    chk("sl_fe_drain", fe_tr[8], 1'b0);

    // RAW hazard: LD then ALU reading A.
    clr_prog();
    prog[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    prog[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) sb.push_back(prog[i]);
    run(40, -1);
    chk("raw_fe_h1", fe_tr[3], 1'b0);
    chk("raw_fe_h2", fe_tr[4], 1'b0);
    chk("raw_fe_go", fe_tr[5], 1'b1);
    chk("raw_s2v_b1", s2v_tr[4], 1'b0);
    chk("raw_s2v_b2", s2v_tr[5], 1'b0);
    chk("raw_s2a_bubble", s2a_tr[4], 1'b0);
    chk("raw_s3a_ld", s3a_tr[4], 1'b1);
    chk("raw_alu_s2v", s2v_tr[6], 1'b1);
    chk("raw_alu_s2a", s2a_tr[6], 1'b1);
    chk("raw_done_at", done_at, 9);

    // Taken jump over I2/I3; a stray start mid-run is ignored.
    clr_prog();
    prog[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    prog[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[5] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    sb.push_back(prog[0]); sb.push_back(prog[1]);
    sb.push_back(prog[4]); sb.push_back(prog[5]);
    start_at = 5;
    run(40, -1);
    start_at = -1;
    chk("jmp_fe_resolve", fe_tr[4], 1'b1);
    chk("jmp_s1v", s1v_tr[5], 1'b0);
    chk("jmp_s2v", s2v_tr[5], 1'b0);
    chk("jmp_s3v", s3v_tr[5], 1'b1);
    chk("jmp_fe_after", fe_tr[5], 1'b1);
    chk("jmp_start_ignored", pr_tr[5], 1'b0);
    chk("jmp_done_at", done_at, 10);

    // Squash and hold in the same cycle: squash wins.
    clr_prog();
    prog[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    prog[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    prog[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    prog[5] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    sb.push_back(prog[0]); sb.push_back(prog[1]);
    sb.push_back(prog[4]); sb.push_back(prog[5]);
    run(40, -1);
    chk("sim_fe_hold", fe_tr[4], 1'b0);
    chk("sim_s1v", s1v_tr[5], 1'b0);
    chk("sim_s2v", s2v_tr[5], 1'b0);
    chk("sim_s3v_jmp", s3v_tr[5], 1'b1);
    chk("sim_s2v_next", s2v_tr[6], 1'b0);
    chk("sim_done_at", done_at, 10);

    // Infinite jump loop: cycle-limit abort.
    clr_prog();
    sb_on = 1'b0;
    prog[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    run(40, -1);
    chk("to_done_at", done_at, LIMIT + 1);
    chk("to_timeout", tmo_seen, 1'b1);
    chk("to_s1v", s1v_tr[LIMIT + 1], 1'b0);
    chk("to_s2v", s2v_tr[LIMIT + 1], 1'b0);
    chk("to_s3v", s3v_tr[LIMIT + 1], 1'b0);

    // RET completes one cycle before the limit: normal completion.
    load_line(11);
    run(40, -1);
    chk("lim_m1_done_at", done_at, LIMIT);
    chk("lim_m1_timeout", tmo_seen, 1'b0);

    // RET reaches stage3 on the limit cycle: timeout wins.
    load_line(12);
    run(40, -1);
    chk("lim_done_at", done_at, LIMIT + 1);
    chk("lim_timeout", tmo_seen, 1'b1);

    // Async reset mid-drain, then a clean rerun from PC 0.
    load_line(5);
    run(40, 8);
    chk("pre_rst_drain_fe", fe_tr[8], 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_drain", outs, 11'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    load_line(5);
    run(40, -1);
    chk("rerun_done_at", done_at, 10);
    chk("rerun_timeout", tmo_seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
